led_pattern_ctrl: RTL and testbench
===================================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, number of LED outputs.
REQ-002 SHALL have parameter NUM_BTNS, default 1, number of raw button inputs.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a button level.
REQ-004 SHALL have parameter SLOW_BIT, default 23, free-running counter bit driving slow blink.
REQ-005 SHALL have parameter FAST_BIT, default 22, counter bit driving fast blink; SLOW_BIT > FAST_BIT.
REQ-006 SHALL have parameter PWM_BITS, default 8, PWM counter and duty width.
REQ-007 SHALL have parameter ACTIVE_LOW, default 1; 1 = LED lit when pin is 0.
REQ-008 SHALL have port clk_50MHz  input  1  sole clock; all logic on rising edge.
REQ-009 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-010 SHALL have port buttons  input  NUM_BTNS  raw, asynchronous, active-low (0 = pressed).
REQ-011 SHALL have port cfg_we  input  1  config write strobe.
REQ-012 SHALL have port cfg_addr  input  $clog2(NUM_LEDS) (min 1)  LED index to configure.
REQ-013 SHALL have port cfg_mode  input  3  mode code for addressed LED.
REQ-014 SHALL have port cfg_duty  input  PWM_BITS  PWM duty for addressed LED.
REQ-015 SHALL have port status_leds  output  NUM_LEDS  LED pins, polarity per ACTIVE_LOW.
REQ-016 SHALL have port btn_event  output  NUM_BTNS  one-cycle pulse per accepted press.
REQ-017 SHALL have port btn_toggle  output  NUM_BTNS  per-button toggle state.

Function
REQ-018 SHALL synchronise each button through two flops before any use.
REQ-019 SHALL debounce per button: debounced level changes only after synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the debounced level restarts the count at 0.
REQ-020 SHALL assert btn_event[b] for exactly one cycle, the cycle after debounced level for b goes 1->0; release produces no event.
REQ-021 SHALL invert btn_toggle[b] on the same edge btn_event[b] is registered high.
REQ-022 SHALL run a free-running counter of SLOW_BIT+1 bits, wrapping to 0 without stall.
REQ-023 SHALL run a free-running PWM_BITS counter pwm_cnt, wrapping 2^PWM_BITS-1 -> 0.
REQ-024 SHALL hold per-LED mode (3 bits) and duty (PWM_BITS); on cfg_we with cfg_addr < NUM_LEDS, write both on that edge; cfg_addr >= NUM_LEDS ignored, no state change.
REQ-025 SHALL compute logical on-state per LED i by mode: 0 off; 1 on; 2 counter[SLOW_BIT]; 3 counter[FAST_BIT]; 4 pwm_cnt < duty (unsigned); 5 btn_toggle[i mod NUM_BTNS]; 6 debounced pressed level of button i mod NUM_BTNS; 7 off (reserved).
REQ-026 SHALL register status_leds; pin = on-state XOR ACTIVE_LOW; output reflects state one cycle after the edge updating it.
REQ-027 SHALL make a config write visible on status_leds at the second edge after cfg_we sampled (write edge + output register).
REQ-028 SHALL treat duty 0 as always off and duty 2^PWM_BITS-1 as on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
REQ-029 SHALL process a config write and a button event on the same cycle independently; both take effect.

Reset
REQ-030 SHALL on reset clear counters and pwm_cnt to 0, all modes to 0, all duties to 0, debounce counters to 0, btn_toggle to 0, btn_event to 0.
REQ-031 SHALL on reset set sync flops and debounced levels to 1 (released).
REQ-032 SHALL on reset drive status_leds to all ACTIVE_LOW (all unlit) from the first edge with reset high.
REQ-033 SHALL give reset priority over cfg_we and pending debounce; a press in progress is discarded and no btn_event issues.

Verification (NUM_LEDS=4, NUM_BTNS=2, DEBOUNCE_CYCLES=4, SLOW_BIT=3, FAST_BIT=2, PWM_BITS=4, ACTIVE_LOW=1)
REQ-034 SHALL verify reset: reset high 2 cycles -> status_leds=4'b1111, btn_event=0, btn_toggle=0.
REQ-035 SHALL verify debounce: buttons[0] low 3 cycles then high -> no btn_event; low held 10 cycles -> exactly one btn_event[0] pulse, btn_toggle[0]=1.
REQ-036 SHALL verify blink: LED0 mode 2, LED1 mode 3 -> LED0 pin period 16 cycles, LED1 period 8 cycles, 50% duty.
REQ-037 SHALL verify PWM: LED2 mode 4 duty 5 -> pin low 5 of every 16 cycles; duty 0 -> constant 1; duty 15 -> low 15/16.
REQ-038 SHALL verify mapping/edges: LED3 mode 5 -> follows btn_toggle[1]; cfg_addr=4 with cfg_we -> no change; write same cycle as btn_event -> both applied.
REQ-039 SHALL verify reset mid-debounce: buttons[1] low 2 cycles, reset 1 cycle -> no btn_event[1], modes back to 0.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   Drives a bank of status LEDs from per-LED patterns and debounces a set
//   of raw push buttons. Each LED has a 3-bit mode and a PWM duty. These
//   are written through a simple config strobe. Every LED can show one of
//   these patterns:
//     off, on, slow blink, fast blink, PWM dimming,
//     a button's toggle state, or a button's debounced pressed level.
//
// Ports
//   clk_50MHz   : sole clock, all logic on the rising edge
//   reset       : synchronous, active-high reset
//   buttons     : raw asynchronous button inputs, active-low (0 = pressed)
//   cfg_we      : config write strobe
//   cfg_addr    : LED index to configure (out-of-range indices are ignored)
//   cfg_mode    : mode code written to the addressed LED
//   cfg_duty    : PWM duty written to the addressed LED
//   status_leds : registered LED pins, polarity set by ACTIVE_LOW
//   btn_event   : one-cycle pulse per accepted press
//   btn_toggle  : per-button state that flips on every accepted press
module led_pattern_ctrl #(
  parameter int NUM_LEDS        = 4,
  parameter int NUM_BTNS        = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SLOW_BIT        = 23,
  parameter int FAST_BIT        = 22,
  parameter int PWM_BITS        = 8,
  parameter int ACTIVE_LOW      = 1,
  localparam int ADDR_W         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk_50MHz,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] buttons,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [2:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [NUM_LEDS-1:0] status_leds,
  output logic [NUM_BTNS-1:0] btn_event,
  output logic [NUM_BTNS-1:0] btn_toggle
);

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_ON     = 3'd1,
    MODE_SLOW   = 3'd2,
    MODE_FAST   = 3'd3,
    MODE_PWM    = 3'd4,
    MODE_TOGGLE = 3'd5,
    MODE_LEVEL  = 3'd6,
    MODE_RSVD   = 3'd7
  } led_mode_e;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic PIN_POL = (ACTIVE_LOW != 0);

  logic [NUM_BTNS-1:0] sync_a;
  logic [NUM_BTNS-1:0] sync_b;
  logic [NUM_BTNS-1:0] deb_level;        // 1 = released, 0 = pressed
  logic [DB_W-1:0]     db_cnt [NUM_BTNS];

  logic [SLOW_BIT:0]   blink_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;

  led_mode_e           mode_q [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_q [NUM_LEDS];

  logic [NUM_LEDS-1:0] led_on;

  // Button path: two-flop synchroniser, then a per-button run-length
  // debounce. The press event and toggle are registered on the same edge
  // that the debounced level falls, so the pulse lines up with the new level.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync_a     <= '1;
      sync_b     <= '1;
      deb_level  <= '1;
      btn_event  <= '0;
      btn_toggle <= '0;
      for (int b = 0; b < NUM_BTNS; b++) begin
        db_cnt[b] <= '0;
      end
    end else begin
      sync_a    <= buttons;
      sync_b    <= sync_a;
      btn_event <= '0;
      for (int b = 0; b < NUM_BTNS; b++) begin
        if (sync_b[b] == deb_level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          db_cnt[b]    <= '0;
          deb_level[b] <= sync_b[b];
          if (!sync_b[b]) begin
            btn_event[b]  <= 1'b1;
            btn_toggle[b] <= ~btn_toggle[b];
          end
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      blink_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
    end
  end

  // Config registers. Indices past the last LED are dropped, which only
  // matters when NUM_LEDS is not a power of two.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      // NOTE: the mode/duty arrays are small register files, not RAM, so
      // they are reset explicitly to give every LED a known "off" pattern.
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= '0;
      end
    end else if (cfg_we && (int'(cfg_addr) < NUM_LEDS)) begin
      mode_q[cfg_addr] <= led_mode_e'(cfg_mode);
      duty_q[cfg_addr] <= cfg_duty;
    end
  end

  // Logical on-state per LED. Button-driven modes wrap the LED index onto
  // the available buttons.
  always_comb begin
    // NOTE: default every bit first so no path through the case infers a latch.
    led_on = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode_q[i])
        MODE_ON:     led_on[i] = 1'b1;
        MODE_SLOW:   led_on[i] = blink_cnt[SLOW_BIT];
        MODE_FAST:   led_on[i] = blink_cnt[FAST_BIT];
        MODE_PWM:    led_on[i] = (pwm_cnt < duty_q[i]);
        MODE_TOGGLE: led_on[i] = btn_toggle[i % NUM_BTNS];
        MODE_LEVEL:  led_on[i] = ~deb_level[i % NUM_BTNS];
        default:     led_on[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      status_leds <= {NUM_LEDS{PIN_POL}};
    end else begin
      status_leds <= led_on ^ {NUM_LEDS{PIN_POL}};
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

  localparam int NL  = 4;
  localparam int NB  = 2;
  localparam int DEB = 4;
  localparam int SB  = 3;
  localparam int FB  = 2;
  localparam int PB  = 4;

  logic          clk_50MHz = 1'b0;
  logic          reset;
  logic [NB-1:0] buttons;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [2:0]    cfg_mode;
  logic [PB-1:0] cfg_duty;
  logic [NL-1:0] status_leds;
  logic [NB-1:0] btn_event;
  logic [NB-1:0] btn_toggle;
  logic [2:0]    status_leds3;
  logic [NB-1:0] btn_event3;
  logic [NB-1:0] btn_toggle3;

  always #10 clk_50MHz = ~clk_50MHz;

  led_pattern_ctrl #(
    .NUM_LEDS(NL), .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DEB), .SLOW_BIT(SB),
    .FAST_BIT(FB), .PWM_BITS(PB), .ACTIVE_LOW(1)
  ) u_dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .buttons(buttons),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .status_leds(status_leds),
    .btn_event(btn_event), .btn_toggle(btn_toggle)
  );

  // Three-LED variant: its 2-bit address can name a non-existent LED 3.
  led_pattern_ctrl #(
    .NUM_LEDS(3), .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DEB), .SLOW_BIT(SB),
    .FAST_BIT(FB), .PWM_BITS(PB), .ACTIVE_LOW(1)
  ) u_dut3 (
    .clk_50MHz(clk_50MHz), .reset(reset), .buttons(buttons),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .status_leds(status_leds3),
    .btn_event(btn_event3), .btn_toggle(btn_toggle3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time since reset drives the blink/PWM patterns,
  // buttons are tracked as a 2-cycle delayed level plus a run length.
  logic          model_ok = 1'b0;
  int            m_cnt;
  logic [NB-1:0] m_s1, m_s2, m_deb, m_evt, m_tog;
  int            m_run  [NB];
  int            m_mode [NL];
  int            m_duty [NL];
  logic [NL-1:0] m_led;

  always @(posedge clk_50MHz) begin
    if (reset) begin
      model_ok = 1'b1;
      m_cnt = 0;
      m_s1 = '1; m_s2 = '1; m_deb = '1; m_evt = '0; m_tog = '0;
      m_led = '1;
      for (int b = 0; b < NB; b++) m_run[b] = 0;
      for (int i = 0; i < NL; i++) begin
        m_mode[i] = 0;
        m_duty[i] = 0;
      end
    end else if (model_ok) begin
      for (int i = 0; i < NL; i++) begin
        logic on;
        case (m_mode[i])
          1:       on = 1'b1;
          2:       on = ((m_cnt >> SB) & 1) == 1;
          3:       on = ((m_cnt >> FB) & 1) == 1;
          4:       on = (m_cnt % (1 << PB)) < m_duty[i];
          5:       on = m_tog[i % NB];
          6:       on = !m_deb[i % NB];
          default: on = 1'b0;
        endcase
        m_led[i] = !on;
      end
      m_evt = '0;
      for (int b = 0; b < NB; b++) begin
        if (m_s2[b] != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_run[b] = 0;
            m_deb[b] = m_s2[b];
            if (!m_s2[b]) begin
              m_evt[b] = 1'b1;
              m_tog[b] = ~m_tog[b];
            end
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = buttons;
      if (cfg_we && int'(cfg_addr) < NL) begin
        m_mode[cfg_addr] = int'(cfg_mode);
        m_duty[cfg_addr] = int'(cfg_duty);
      end
      m_cnt++;
    end
  end

  int ev0 = 0;
  int ev1 = 0;

  always @(negedge clk_50MHz) begin
    if (model_ok) begin
      check("model_leds",   32'(status_leds), 32'(m_led));
      check("model_event",  32'(btn_event),   32'(m_evt));
      check("model_toggle", 32'(btn_toggle),  32'(m_tog));
      if (btn_event[0]) ev0++;
      if (btn_event[1]) ev1++;
    end
  end

  task automatic cfg_write(input int addr, input int mode, input int duty);
    cfg_we   = 1'b1;
    cfg_addr = 2'(addr);
    cfg_mode = 3'(mode);
    cfg_duty = 4'(duty);
    @(negedge clk_50MHz);
    cfg_we = 1'b0;
  endtask

  // Samples n+1 negedges of one pin: lit (low) count over the first n,
  // level changes over the n intervals.
  task automatic measure(input int idx, input int n, output int lows, output int togs);
    logic prev, cur;
    lows = 0;
    togs = 0;
    prev = status_leds[idx];
    if (!prev) lows++;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_50MHz);
      cur = status_leds[idx];
      if (k < n && !cur) lows++;
      if (cur != prev) togs++;
      prev = cur;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, togs;
    int hold [NB];

    reset = 1'b1; buttons = '1; cfg_we = 1'b0;
    cfg_addr = '0; cfg_mode = '0; cfg_duty = '0;
    repeat (2) @(negedge clk_50MHz);
    check("reset_leds",   32'(status_leds),  32'h0000_000f);
    check("reset_event",  32'(btn_event),    32'h0);
    check("reset_toggle", 32'(btn_toggle),   32'h0);
    check("reset_leds3",  32'(status_leds3), 32'h0000_0007);
    reset = 1'b0;

    // Out-of-range address on the 3-LED variant is ignored.
    cfg_write(3, 1, 0);
    @(negedge clk_50MHz);
    check("oor_ignored3", 32'(status_leds3), 32'h7);
    check("addr3_valid4", 32'(status_leds),  32'h7);
    cfg_write(2, 1, 0);
    @(negedge clk_50MHz);
    check("inrange3", 32'(status_leds3), 32'h3);
    cfg_write(3, 0, 0);
    cfg_write(2, 0, 0);

    // Short glitch, then a real press and a release.
    buttons[0] = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    buttons[0] = 1'b1;
    repeat (10) @(negedge clk_50MHz);
    check("glitch_no_event", 32'(ev0), 32'd0);
    buttons[0] = 1'b0;
    repeat (10) @(negedge clk_50MHz);
    check("press_one_event", 32'(ev0), 32'd1);
    check("press_toggle0",   32'(btn_toggle[0]), 32'd1);
    buttons[0] = 1'b1;
    repeat (10) @(negedge clk_50MHz);
    check("release_no_event", 32'(ev0), 32'd1);

    // Blink periods.
    cfg_write(0, 2, 0);
    cfg_write(1, 3, 0);
    @(negedge clk_50MHz);
    measure(0, 32, lows, togs);
    check("slow_lows", 32'(lows), 32'd16);
    check("slow_togs", 32'(togs), 32'd4);
    measure(1, 32, lows, togs);
    check("fast_lows", 32'(lows), 32'd16);
    check("fast_togs", 32'(togs), 32'd8);

    // PWM duties 5, 0, 15.
    cfg_write(2, 4, 5);
    @(negedge clk_50MHz);
    measure(2, 16, lows, togs);
    check("pwm5_lows", 32'(lows), 32'd5);
    cfg_write(2, 4, 0);
    @(negedge clk_50MHz);
    measure(2, 16, lows, togs);
    check("pwm0_lows", 32'(lows), 32'd0);
    check("pwm0_togs", 32'(togs), 32'd0);
    cfg_write(2, 4, 15);
    @(negedge clk_50MHz);
    measure(2, 16, lows, togs);
    check("pwm15_lows", 32'(lows), 32'd15);

    // LED3 follows btn_toggle[1]; config write lands on the event cycle.
    cfg_write(3, 5, 0);
    @(negedge clk_50MHz);
    check("toggle_map_idle", 32'(status_leds[3]), 32'd1);
    buttons[1] = 1'b0;
    repeat (5) @(negedge clk_50MHz);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_mode = 3'd1; cfg_duty = 4'd0;
    @(negedge clk_50MHz);
    cfg_we = 1'b0;
    check("same_cycle_event", 32'(btn_event), 32'h2);
    @(negedge clk_50MHz);
    check("same_cycle_led0", 32'(status_leds[0]), 32'd0);
    check("toggle_map_led3", 32'(status_leds[3]), 32'd0);
    buttons[1] = 1'b1;
    repeat (10) @(negedge clk_50MHz);
    check("ev1_count", 32'(ev1), 32'd1);

    // Reset during a press in progress.
    buttons[1] = 1'b0;
    repeat (2) @(negedge clk_50MHz);
    reset = 1'b1;
    buttons[1] = 1'b1;
    @(negedge clk_50MHz);
    reset = 1'b0;
    repeat (12) @(negedge clk_50MHz);
    check("mid_reset_no_event", 32'(ev1), 32'd1);
    check("mid_reset_leds",     32'(status_leds), 32'hf);
    check("mid_reset_toggle",   32'(btn_toggle),  32'h0);

    // Random traffic against the model.
    for (int b = 0; b < NB; b++) hold[b] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (hold[b] == 0) begin
          buttons[b] = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 10));
        end else begin
          hold[b]--;
        end
      end
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_mode = 3'($urandom_range(0, 7));
      cfg_duty = 4'($urandom_range(0, 15));
      reset    = ($urandom_range(0, 299) == 0);
      @(negedge clk_50MHz);
    end
    reset = 1'b0;
    cfg_we = 1'b0;
    repeat (4) @(negedge clk_50MHz);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
